// File: rtl/mem_access_sequencer.sv
// Single-port memory sequencer that arbitrates instruction fetches and load/stores.
// Optional ARB_ROUND_ROBIN_EN swaps fixed data priority for alternating grants.
module mem_access_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] instruction,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_CAP, WR} stateT;

  stateT             state, nextState;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] wdataReg;
  logic              ownerFetch;
  logic              grantFetch, grantData;
  logic              fetchPend, dataPend;
`ifdef ARB_ROUND_ROBIN_EN
  logic              lastGrantData;
`endif

  // A requester whose ack is high this cycle is masked so a held req is not re-taken.
  assign fetchPend = fetch_req & ~fetch_ack;
  assign dataPend  = data_req  & ~data_ack;

  always_comb begin
    nextState  = state;
    grantFetch = 1'b0;
    grantData  = 1'b0;
    case (state)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (fetchPend && dataPend) begin
          grantData  = ~lastGrantData;
          grantFetch = lastGrantData;
        end else begin
          grantData  = dataPend;
          grantFetch = fetchPend;
        end
`else
        grantData  = dataPend;
        grantFetch = fetchPend & ~dataPend;
`endif
        if (grantData)       nextState = data_we ? WR : RD_ADDR;
        else if (grantFetch) nextState = RD_ADDR;
      end
      RD_ADDR: nextState = RD_CAP;
      RD_CAP:  nextState = IDLE;
      WR:      nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fetch_ack   <= 1'b0;
      data_ack    <= 1'b0;
      instruction <= '0;
      mem_data    <= '0;
      addrReg     <= '0;
      wdataReg    <= '0;
      ownerFetch  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      lastGrantData <= 1'b1;
`endif
    end else begin
      state     <= nextState;
      fetch_ack <= (state == RD_CAP) && ownerFetch;
      data_ack  <= ((state == RD_CAP) && !ownerFetch) || (state == WR);
      if (grantFetch || grantData) begin
        addrReg    <= grantData ? data_addr : fetch_addr;
        ownerFetch <= grantFetch;
`ifdef ARB_ROUND_ROBIN_EN
        lastGrantData <= grantData;
`endif
      end
      if (grantData && data_we) wdataReg <= data_wdata;
      // Synchronous-read data arrives in the cycle after the address was presented.
      if (state == RD_CAP) begin
        if (ownerFetch) instruction <= mem_rdata;
        else            mem_data    <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addrReg;
  assign mem_wdata = wdataReg;
  assign mem_we    = (state == WR);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: transaction-level model checked every cycle
// plus literal expectations for latency, data values and arbitration order.
module tb_mem_access_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [15:0] fetch_addr = '0, data_addr = '0, data_wdata = '0;
  logic        fetch_ack, data_ack, mem_we, busy;
  logic [15:0] instruction, mem_data, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;

  int checks = 0, failures = 0;
  bit chkEn = 0;

  always #5 clk = ~clk;

  mem_access_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .instruction(instruction),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .mem_data(mem_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Synchronous-read memory, reseeded on reset.
  bit [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (reset) begin
      mem[16'h0010] <= 16'hA5C3;
      mem[16'h0020] <= 16'h5A5A;
      mem[16'h0200] <= 16'h0000;
      mem[16'h0300] <= 16'h1111;
      mem[16'h0301] <= 16'h2222;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Transaction model: one transaction at a time, reads take 2 busy cycles, stores 1.
  bit          mActive, mIsFetch, mIsStore, mFa, mDa, mLastData;
  int          mLeft;
  logic [15:0] mExp, mInstr, mMemData, mMemAddr, mMemWdata;
  always @(posedge clk) begin : model
    bit fa, da, fr, dr, gf, gd;
    fa = 0; da = 0; gf = 0; gd = 0;
    if (reset) begin
      mActive <= 0; mFa <= 0; mDa <= 0; mLeft <= 0; mLastData <= 1;
      mInstr <= '0; mMemData <= '0; mMemAddr <= '0; mMemWdata <= '0;
    end else if (mActive) begin
      if (mLeft == 1) begin
        mActive <= 0;
        if (mIsFetch) begin mInstr <= mExp; fa = 1; end
        else begin da = 1; if (!mIsStore) mMemData <= mExp; end
      end
      mLeft <= mLeft - 1;
      mFa <= fa; mDa <= da;
    end else begin
      fr = fetch_req && !mFa;
      dr = data_req && !mDa;
`ifdef ARB_ROUND_ROBIN_EN
      if (fr && dr) begin gd = !mLastData; gf = mLastData; end
      else begin gd = dr; gf = fr; end
`else
      gd = dr; gf = fr && !dr;
`endif
      if (gf || gd) begin
        mActive  <= 1;
        mIsFetch <= gf;
        mIsStore <= gd && data_we;
        mLeft    <= (gd && data_we) ? 1 : 2;
        mMemAddr <= gd ? data_addr : fetch_addr;
        mExp     <= mem[gd ? data_addr : fetch_addr];
        if (gd && data_we) mMemWdata <= data_wdata;
        mLastData <= gd;
      end
      mFa <= 0; mDa <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      chk("fetch_ack", fetch_ack, mFa);
      chk("data_ack", data_ack, mDa);
      chk("busy", busy, mActive);
      chk("mem_we", mem_we, mActive && mIsStore);
      chk("instruction", instruction, mInstr);
      chk("mem_data", mem_data, mMemData);
      chk("mem_addr", mem_addr, mMemAddr);
      chk("mem_wdata", mem_wdata, mMemWdata);
      chk("ack_overlap", fetch_ack & data_ack, 0);
    end
  end

  int weCnt = 0;
  logic [15:0] weAddr, weData;
  always @(negedge clk) begin
    if (chkEn && mem_we) begin
      weCnt++; weAddr = mem_addr; weData = mem_wdata;
    end
  end

  task automatic waitAck(input bit isFetch, output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (isFetch ? fetch_ack : data_ack) begin lat = n - 1; break; end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL ack_timeout actual=none expected=ack within 20 cycles fetch=%0d", isFetch);
    end
  endtask

  task automatic startReq(input bit isFetch, input bit we, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    if (isFetch) begin fetch_addr = a; fetch_req = 1; end
    else begin data_addr = a; data_wdata = d; data_we = we; data_req = 1; end
  endtask

  task automatic doReset();
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
  endtask

  initial begin
    int lat, w0, k;
    int order [2];
    repeat (2) @(posedge clk);
    #1 chkEn = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_mem_addr", mem_addr, 0);
    reset = 0;

    // Fetch
    w0 = weCnt;
    startReq(1, 0, 16'h0010, 0);
    waitAck(1, lat); fetch_req = 0;
    chk("fetch_latency", lat, 3);
    chk("fetch_instr", instruction, 16'hA5C3);
    chk("fetch_no_we", weCnt - w0, 0);

    // Store
    w0 = weCnt;
    startReq(0, 1, 16'h0200, 16'h1234);
    waitAck(0, lat); data_req = 0;
    chk("store_latency", lat, 2);
    chk("store_we_cycles", weCnt - w0, 1);
    chk("store_addr", weAddr, 16'h0200);
    chk("store_wdata", weData, 16'h1234);

    // Load back the stored word
    startReq(0, 0, 16'h0200, 0);
    waitAck(0, lat); data_req = 0;
    chk("load_latency", lat, 3);
    chk("load_data", mem_data, 16'h1234);

    // Contention right after reset
    doReset();
    fetch_addr = 16'h0010; data_addr = 16'h0020; data_we = 0;
    fetch_req = 1; data_req = 1;
    k = 0;
    for (int n = 0; n < 30 && k < 2; n++) begin
      @(negedge clk);
      if (fetch_ack) begin order[k] = 1; k++; fetch_req = 0; end
      if (data_ack && k < 2) begin order[k] = 0; k++; data_req = 0; end
    end
    fetch_req = 0; data_req = 0;
    chk("contention_acks", k, 2);
`ifdef ARB_ROUND_ROBIN_EN
    chk("contention_first", order[0], 1);
    chk("contention_second", order[1], 0);
`else
    chk("contention_first", order[0], 0);
    chk("contention_second", order[1], 1);
`endif
    chk("contention_instr", instruction, 16'hA5C3);
    chk("contention_data", mem_data, 16'h5A5A);

    // Back-to-back loads with data_req held through the ack cycle
    startReq(0, 0, 16'h0300, 0);
    waitAck(0, lat);
    chk("b2b_first", mem_data, 16'h1111);
    data_addr = 16'h0301;
    waitAck(0, lat); data_req = 0;
    chk("b2b_gap", lat, 3);
    chk("b2b_second", mem_data, 16'h2222);

    // Reset during WR
    startReq(0, 1, 16'h0400, 16'hBEEF);
    @(negedge clk);
    @(negedge clk);
    chk("wr_state_we", mem_we, 1);
    reset = 1; data_req = 0;
    @(negedge clk);
    chk("wr_rst_busy", busy, 0);
    chk("wr_rst_we", mem_we, 0);
    chk("wr_rst_ack", data_ack, 0);
    chk("wr_rst_addr", mem_addr, 0);
    chk("wr_rst_wdata", mem_wdata, 0);
    chk("wr_rst_mem_data", mem_data, 0);
    reset = 0;
    repeat (3) begin @(negedge clk); chk("wr_rst_no_ack", data_ack, 0); end

    // Reset during RD_CAP, then re-arbitrate a fresh fetch
    startReq(1, 0, 16'h0010, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rdcap_busy", busy, 1);
    reset = 1; fetch_req = 0;
    @(negedge clk);
    chk("rdcap_rst_ack", fetch_ack, 0);
    chk("rdcap_rst_instr", instruction, 0);
    chk("rdcap_rst_busy", busy, 0);
    reset = 0;
    @(negedge clk);
    chk("rdcap_rst_no_ack", fetch_ack, 0);
    startReq(1, 0, 16'h0010, 0);
    waitAck(1, lat); fetch_req = 0;
    chk("refetch_latency", lat, 3);
    chk("refetch_instr", instruction, 16'hA5C3);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter: ADDR_W, 16, memory address width.
REQ-002 Parameter: DATA_W, 16, memory data and instruction width.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: fetch_req  input  1  instruction-fetch request from the controller; held until fetch_ack.
REQ-006 Port: fetch_addr  input  ADDR_W  PC address for the fetch.
REQ-007 Port: fetch_ack  output  1  one-cycle pulse; instruction holds the new word.
REQ-008 Port: instruction  output  DATA_W  registered fetched instruction word.
REQ-009 Port: data_req  input  1  load/store request from the datapath; held until data_ack.
REQ-010 Port: data_we  input  1  1 = store, 0 = load; sampled with data_req.
REQ-011 Port: data_addr  input  ADDR_W  load/store address (regA).
REQ-012 Port: data_wdata  input  DATA_W  store data (bus output).
REQ-013 Port: data_ack  output  1  one-cycle pulse; load data valid or store committed.
REQ-014 Port: mem_data  output  DATA_W  registered load result.
REQ-015 Port: mem_addr  output  ADDR_W  address to memory port 1, driven from the internal latched-address register.
REQ-016 Port: mem_wdata  output  DATA_W  write data to memory port 1, driven from the internal latched-write-data register.
REQ-017 Port: mem_we  output  1  memory port 1 write enable.
REQ-018 Port: mem_rdata  input  DATA_W  memory port 1 read data, valid one cycle after address (synchronous read).
REQ-019 Port: busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, RD_ADDR, RD_CAP, WR.
REQ-021 In IDLE with a granted request, the block SHALL latch the address (and write data on a store) and the requester identity, then move to RD_ADDR (fetch or load) or WR (store).
REQ-022 RD_ADDR SHALL present the latched address with mem_we=0, then go to RD_CAP unconditionally.
REQ-023 RD_CAP SHALL capture mem_rdata into instruction (fetch) or mem_data (load), then go to IDLE with that requester's ack high for the following cycle.
REQ-024 WR SHALL assert mem_we=1 for exactly one cycle, then go to IDLE with data_ack high for the following cycle.
REQ-025 Read latency: ack SHALL be high 3 cycles after the edge at which req is first sampled in IDLE; store latency SHALL be 2 cycles.
REQ-026 mem_we SHALL be 1 only in WR; mem_addr and mem_wdata SHALL hold their last values in all other states.
REQ-027 Requests arriving while busy=1 SHALL wait and not be lost; the other requester is never interrupted.
REQ-028 In the cycle its ack is high, a requester's req SHALL be masked (not sampled); the requester must deassert or present a new request after that cycle.
REQ-029 instruction and mem_data SHALL change only in RD_CAP for their own requester.
REQ-030 At most one of fetch_ack/data_ack SHALL be high in any cycle.

Reset
REQ-031 Reset SHALL force: state IDLE, fetch_ack=0, data_ack=0, mem_we=0, busy=0, instruction=0, mem_data=0, mem_addr=0, mem_wdata=0, last-grant=DATA.
REQ-032 Reset asserted mid-transaction SHALL abort it: no ack issued, mem_we low from the next cycle, requests re-arbitrated after reset releases.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN defined: when both requests are pending in IDLE, the grant SHALL go to the requester not granted last; last-grant updates on each grant.
REQ-034 ARB_ROUND_ROBIN_EN undefined: data_req SHALL always win over fetch_req; the last-grant register is absent.

Verification
REQ-035 Fetch: fetch_req=1, fetch_addr=0x0010, mem_rdata=0xA5C3 in RD_CAP -> fetch_ack pulse 3 cycles later, instruction=0xA5C3, mem_we never 1.
REQ-036 Store: data_req=1, data_we=1, addr 0x0200, wdata 0x1234 -> exactly one cycle mem_we=1, mem_addr=0x0200, mem_wdata=0x1234; data_ack 2 cycles later.
REQ-037 Contention: fetch_req and data_req (load) rise together after reset -> round robin: fetch granted first, then data; fixed priority: data first; no overlapping acks.
REQ-038 Back-to-back: data_req held after data_ack with new address 0x0301 -> masked in ack cycle, new load starts next cycle, mem_data updates only after the second RD_CAP.
REQ-039 Reset in WR or RD_CAP -> no ack, all outputs at reset values next cycle, busy=0.
